// File: rtl/sized_data_memory.sv
// Byte/half/word data memory with valid/ready request, fixed wait states and fault reporting.
// Without SIZED_DATA_MEMORY_INIT_EN the array is zero-filled; with it the array starts unknown.
module sized_data_memory #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        resp_valid,
    output logic [31:0] read_data,
    output logic        fault
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [31:0] mem [DEPTH_WORDS];

`ifndef SIZED_DATA_MEMORY_INIT_EN
    initial begin
        for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] = 32'h0;
        end
    end
`endif

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] read_data_q, read_data_d;
    logic        fault_q, fault_d;

    // With zero wait states the access completes on the accept edge, so use the live inputs.
    logic        cur_we;
    logic [1:0]  cur_size;
    logic        cur_uns;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_fault;
    logic        enter_resp;
    logic        wr_en;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic [31:0] rword;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_val;
    logic [3:0]  be;
    logic [31:0] wlanes;

    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = req_we;
            cur_size  = req_size;
            cur_uns   = req_unsigned;
            cur_addr  = address;
            cur_wdata = write_data;
        end else begin
            cur_we    = we_q;
            cur_size  = size_q;
            cur_uns   = uns_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    assign idx  = cur_addr[AW+1:2];
    assign lane = cur_addr[1:0];

    always_comb begin
        cur_fault = (cur_size == 2'b11)
                  | ((cur_size == 2'b01) & cur_addr[0])
                  | ((cur_size == 2'b10) & (cur_addr[1:0] != 2'b00))
                  | (cur_addr[31:AW+2] != '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = address;
                    wdata_d = write_data;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign wr_en      = enter_resp && cur_we && !cur_fault;

    assign rword = mem[idx];
    assign rbyte = rword[{lane, 3'b000} +: 8];
    assign rhalf = rword[{lane[1], 4'b0000} +: 16];

    always_comb begin
        case (cur_size)
            2'b00:   load_val = {{24{~cur_uns & rbyte[7]}}, rbyte};
            2'b01:   load_val = {{16{~cur_uns & rhalf[15]}}, rhalf};
            default: load_val = rword;
        endcase
    end

    always_comb begin
        case (cur_size)
            2'b00: begin
                be     = 4'b0001 << lane;
                wlanes = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be     = 4'b0011 << {lane[1], 1'b0};
                wlanes = {2{cur_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = cur_wdata;
            end
        endcase
    end

    always_comb begin
        read_data_d = 32'h0;
        fault_d     = 1'b0;
        if (enter_resp) begin
            fault_d = cur_fault;
            if (!cur_fault && !cur_we) begin
                read_data_d = load_val;
            end
        end
    end

    // Array is never reset; an aborted request cannot write because state_q is forced to idle.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            read_data_q <= 32'h0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            fault_q     <= fault_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign read_data  = read_data_q;
    assign fault      = fault_q;

endmodule
